// File: rtl/stat_ctrl.sv
// -----------------------------------------------------------------------------
// stat_ctrl -- control FSM for the instruction-type statistics counters.
//
// Gates the counters on and off, pulses their clear line, and on a snapshot
// freezes them, copies four live counter values into shadow registers and
// streams those four words out over a valid/ready interface.
//
// Optional feature: define STAT_WINDOW_EN to add the window_len port and a
// free-running window counter that triggers periodic automatic snapshots.
//
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous active-high reset
//   cmd_start    in   1   start counting (IDLE only)
//   cmd_stop     in   1   stop counting (deferred while a snapshot is busy)
//   cmd_clear    in   1   request a one-cycle counter clear (IDLE/RUN only)
//   cmd_snap     in   1   request a snapshot (IDLE/RUN only)
//   r_cnt        in   32  live R-type counter
//   i_cnt        in   32  live I-type counter
//   j_cnt        in   32  live J-type counter
//   tot_cnt      in   32  live total counter
//   window_len   in   32  auto-snapshot period (STAT_WINDOW_EN builds only)
//   cnt_en       out  1   registered count enable, high exactly in RUN
//   cnt_clr      out  1   registered one-cycle clear pulse
//   out_valid    out  1   readout word valid
//   out_ready    in   1   readout word accepted
//   out_data     out  32  readout word (r, i, j, total in that order)
//   out_idx      out  2   index of the current readout word
//   out_last     out  1   high on the final readout word
//   state        out  2   current FSM state (IDLE=0 RUN=1 SNAP=2 SEND=3)
//   busy         out  1   high in SNAP or SEND
// -----------------------------------------------------------------------------
module stat_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        cmd_clear,
  input  logic        cmd_snap,
  input  logic [31:0] r_cnt,
  input  logic [31:0] i_cnt,
  input  logic [31:0] j_cnt,
  input  logic [31:0] tot_cnt,
`ifdef STAT_WINDOW_EN
  input  logic [31:0] window_len,
`endif
  output logic        cnt_en,
  output logic        cnt_clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_idx,
  output logic        out_last,
  output logic [1:0]  state,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SNAP = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [3:0][31:0] shadow_q;
  logic [1:0]       idx_q;
  logic             from_run_q;
  logic             stop_pend_q;
  logic             cnt_en_q;
  logic             cnt_clr_q;
  logic             win_expire;
  logic             handshake;
  logic             send_done;
  logic             stop_seen;
  logic             is_busy;

  assign is_busy   = (state_q == SNAP) || (state_q == SEND);
  assign handshake = (state_q == SEND) && out_ready;
  assign send_done = handshake && (idx_q == 2'd3);
  // A stop arriving on the very cycle the last word is accepted still counts.
  assign stop_seen = stop_pend_q || cmd_stop;

`ifdef STAT_WINDOW_EN
  logic [31:0] win_cnt_q;

  assign win_expire = (state_q == RUN) && (window_len != 32'd0) &&
                      (win_cnt_q == window_len - 32'd1);

  // Window counter: counts RUN cycles, restarts whenever SNAP or IDLE is
  // entered, and simply holds during SNAP/SEND.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt_q <= 32'd0;
    end else if ((state_q == RUN) && (state_d == RUN)) begin
      win_cnt_q <= win_cnt_q + 32'd1;
    end else if ((state_d == SNAP) || (state_d == IDLE)) begin
      win_cnt_q <= 32'd0;
    end
  end
`else
  assign win_expire = 1'b0;
`endif

  // Next-state logic; stop beats snapshot/expiry in RUN, snapshot beats
  // start in IDLE, and SNAP/SEND ignore every command except stop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_snap)       state_d = SNAP;
        else if (cmd_start) state_d = RUN;
      end
      RUN: begin
        if (cmd_stop)                    state_d = IDLE;
        else if (cmd_snap || win_expire) state_d = SNAP;
      end
      SNAP: state_d = SEND;
      SEND: begin
        if (send_done) state_d = (from_run_q && !stop_seen) ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus the registered counter controls; cnt_en is
  // registered from the next state so it tracks RUN exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_en_q   <= 1'b0;
      cnt_clr_q  <= 1'b0;
      from_run_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_en_q  <= (state_d == RUN);
      cnt_clr_q <= cmd_clear && !is_busy;
      if ((state_q != SNAP) && (state_d == SNAP))
        from_run_q <= (state_q == RUN);
    end
  end

  // Deferred stop: remembered through SNAP/SEND, dropped when SEND exits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stop_pend_q <= 1'b0;
    end else if (send_done) begin
      stop_pend_q <= 1'b0;
    end else if (is_busy && cmd_stop) begin
      stop_pend_q <= 1'b1;
    end
  end

  // Shadow capture on the SNAP exit edge and readout index stepping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      idx_q    <= 2'd0;
    end else if (state_q == SNAP) begin
      shadow_q <= {tot_cnt, j_cnt, i_cnt, r_cnt};
      idx_q    <= 2'd0;
    end else if (handshake) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  assign cnt_en    = cnt_en_q;
  assign cnt_clr   = cnt_clr_q;
  assign out_valid = (state_q == SEND);
  assign out_data  = (state_q == SEND) ? shadow_q[idx_q] : 32'd0;
  assign out_idx   = idx_q;
  assign out_last  = (state_q == SEND) && (idx_q == 2'd3);
  assign state     = state_q;
  assign busy      = is_busy;

endmodule

// File: tb/tb_stat_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stat_ctrl -- self-checking bench for stat_ctrl.
// Directed vector table, hand-written corner sequences, then random commands
// checked against a queue-based behavioural model.
// -----------------------------------------------------------------------------
module tb_stat_ctrl;

  logic        clk;
  logic        reset;
  logic        cmd_start, cmd_stop, cmd_clear, cmd_snap;
  logic [31:0] r_cnt, i_cnt, j_cnt, tot_cnt;
  logic        cnt_en, cnt_clr, out_valid, out_ready, out_last, busy;
  logic [31:0] out_data;
  logic [1:0]  out_idx, state;
`ifdef STAT_WINDOW_EN
  logic [31:0] window_len;
`endif

  int total = 0;
  int bad   = 0;

  stat_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_start (cmd_start),
    .cmd_stop  (cmd_stop),
    .cmd_clear (cmd_clear),
    .cmd_snap  (cmd_snap),
    .r_cnt     (r_cnt),
    .i_cnt     (i_cnt),
    .j_cnt     (j_cnt),
    .tot_cnt   (tot_cnt),
`ifdef STAT_WINDOW_EN
    .window_len(window_len),
`endif
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .state     (state),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed vector: inputs for one cycle, outputs expected after that edge.
  typedef struct {
    logic        start, stop, clear, snap, ready;
    logic [1:0]  st;
    logic        en, clr, valid;
    logic [31:0] data;
    logic [1:0]  idx;
    logic        last;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(input logic start, stop, clear, snap, ready,
                              input logic [1:0] st, input logic en, clr, valid,
                              input logic [31:0] data, input logic [1:0] idx,
                              input logic last);
    vec_t v;
    v.start = start; v.stop = stop; v.clear = clear; v.snap = snap;
    v.ready = ready; v.st = st; v.en = en; v.clr = clr; v.valid = valid;
    v.data = data; v.idx = idx; v.last = last;
    return v;
  endfunction

  // Behavioural model: a snapshot is a queue of four words to deliver.
  bit          m_run, m_snap, m_resume, m_stop, m_clr;
  int unsigned m_win;
  logic [31:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] st, input logic en,
                             input logic clr, input logic valid, input logic [31:0] data,
                             input logic [1:0] idx, input logic last);
    chk({tag, ".state"}, {30'd0, state}, {30'd0, st});
    chk({tag, ".cnt_en"}, {31'd0, cnt_en}, {31'd0, en});
    chk({tag, ".cnt_clr"}, {31'd0, cnt_clr}, {31'd0, clr});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, valid});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, st[1]});
    if (valid) begin
      chk({tag, ".out_data"}, out_data, data);
      chk({tag, ".out_idx"}, {30'd0, out_idx}, {30'd0, idx});
      chk({tag, ".out_last"}, {31'd0, out_last}, {31'd0, last});
    end
  endtask

  task automatic applyStimulus(input logic start, stop, clear, snap, ready);
    cmd_start = start; cmd_stop = stop; cmd_clear = clear; cmd_snap = snap;
    out_ready = ready;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic modelReset();
    m_run = 0; m_snap = 0; m_resume = 0; m_stop = 0; m_clr = 0; m_win = 0;
    q.delete();
  endtask

  function automatic logic [1:0] modelState();
    if (m_snap)          return 2'd2;
    if (q.size() != 0)   return 2'd3;
    if (m_run)           return 2'd1;
    return 2'd0;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    bit busy_now;
    bit expiry;
    busy_now = m_snap || (q.size() != 0);
    m_clr = cmd_clear && !busy_now;
    expiry = 1'b0;
`ifdef STAT_WINDOW_EN
    expiry = (window_len != 0) && (m_win == window_len - 1);
`endif
    if (m_snap) begin
      q.push_back(r_cnt); q.push_back(i_cnt); q.push_back(j_cnt); q.push_back(tot_cnt);
      m_snap = 0;
      if (cmd_stop) m_stop = 1;
    end else if (q.size() != 0) begin
      if (cmd_stop) m_stop = 1;
      if (out_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          m_run  = m_resume && !m_stop;
          m_stop = 0;
          m_win  = 0;
        end
      end
    end else if (m_run) begin
      if (cmd_stop) begin
        m_run = 0; m_win = 0;
      end else if (cmd_snap || expiry) begin
        m_snap = 1; m_resume = 1; m_win = 0;
      end else begin
        m_win++;
      end
    end else if (cmd_snap) begin
      m_snap = 1; m_resume = 0;
    end else if (cmd_start) begin
      m_run = 1;
    end
  endtask

  task automatic checkModel(input string tag);
    logic [1:0] st;
    st = modelState();
    if (q.size() != 0)
      checkOutput(tag, st, 1'b0, m_clr, 1'b1, q[0], 2'(4 - q.size()), q.size() == 1);
    else
      checkOutput(tag, st, st == 2'd1, m_clr, 1'b0, 32'd0, 2'd0, 1'b0);
  endtask

  initial begin
    int en_cyc, clr_seen;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    r_cnt = 32'd7; i_cnt = 32'd3; j_cnt = 32'd1; tot_cnt = 32'd11;
`ifdef STAT_WINDOW_EN
    window_len = 32'd0;
`endif

    tbl[0]  = mk(1,0,0,0,0, 2'd1,1,0,0, 0,0,0);
    tbl[1]  = mk(0,0,0,0,0, 2'd1,1,0,0, 0,0,0);
    tbl[2]  = mk(0,0,0,1,0, 2'd2,0,0,0, 0,0,0);
    tbl[3]  = mk(0,0,0,0,1, 2'd3,0,0,1, 7,0,0);
    tbl[4]  = mk(0,0,0,0,1, 2'd3,0,0,1, 3,1,0);
    tbl[5]  = mk(0,0,0,0,1, 2'd3,0,0,1, 1,2,0);
    tbl[6]  = mk(0,0,0,0,1, 2'd3,0,0,1, 11,3,1);
    tbl[7]  = mk(0,0,0,0,1, 2'd1,1,0,0, 0,0,0);
    tbl[8]  = mk(0,0,1,1,0, 2'd2,0,1,0, 0,0,0);
    tbl[9]  = mk(0,0,1,0,0, 2'd3,0,0,1, 7,0,0);
    tbl[10] = mk(0,0,0,0,1, 2'd3,0,0,1, 3,1,0);
    tbl[11] = mk(0,0,0,0,0, 2'd3,0,0,1, 3,1,0);
    tbl[12] = mk(0,0,1,0,0, 2'd3,0,0,1, 3,1,0);
    tbl[13] = mk(0,1,0,0,0, 2'd3,0,0,1, 3,1,0);
    tbl[14] = mk(0,0,0,0,1, 2'd3,0,0,1, 1,2,0);
    tbl[15] = mk(0,0,0,0,1, 2'd3,0,0,1, 11,3,1);
    tbl[16] = mk(0,0,0,0,1, 2'd0,0,0,0, 0,0,0);
    tbl[17] = mk(0,0,1,0,0, 2'd0,0,1,0, 0,0,0);
    tbl[18] = mk(0,0,1,0,0, 2'd0,0,1,0, 0,0,0);
    tbl[19] = mk(0,0,0,0,0, 2'd0,0,0,0, 0,0,0);
    tbl[20] = mk(1,0,0,0,0, 2'd1,1,0,0, 0,0,0);
    tbl[21] = mk(0,1,1,0,0, 2'd0,0,1,0, 0,0,0);
    tbl[22] = mk(0,0,0,0,0, 2'd0,0,0,0, 0,0,0);
    tbl[23] = mk(0,0,0,1,0, 2'd2,0,0,0, 0,0,0);
    tbl[24] = mk(0,0,0,0,1, 2'd3,0,0,1, 7,0,0);
    tbl[25] = mk(0,0,0,0,1, 2'd3,0,0,1, 3,1,0);
    tbl[26] = mk(0,0,0,0,1, 2'd3,0,0,1, 1,2,0);
    tbl[27] = mk(0,0,0,0,1, 2'd3,0,0,1, 11,3,1);
    tbl[28] = mk(0,0,0,0,1, 2'd0,0,0,0, 0,0,0);

    // Reset state.
    doReset();
    checkOutput("reset", 2'd0, 0, 0, 0, 0, 0, 0);
    chk("reset.out_data", out_data, 32'd0);
    chk("reset.out_idx", {30'd0, out_idx}, 32'd0);
    chk("reset.out_last", {31'd0, out_last}, 32'd0);

    // Start, five RUN cycles, stop.
    en_cyc = 0; clr_seen = 0;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (cnt_en) en_cyc++;
      if (cnt_clr) clr_seen++;
      cmd_stop = (k == 4);
      @(negedge clk);
    end
    cmd_stop = 1'b0;
    chk("run5.en_cycles", en_cyc, 5);
    chk("run5.clr_cycles", clr_seen, 0);
    chk("run5.state", {30'd0, state}, 32'd0);

    // Directed table.
    doReset();
    for (int n = 0; n < 29; n++) begin
      applyStimulus(tbl[n].start, tbl[n].stop, tbl[n].clear, tbl[n].snap, tbl[n].ready);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", n), tbl[n].st, tbl[n].en, tbl[n].clr,
                  tbl[n].valid, tbl[n].data, tbl[n].idx, tbl[n].last);
    end
    applyStimulus(0, 0, 0, 0, 0);

    // Reset in the middle of SEND at idx 2.
    cmd_snap = 1'b1;
    @(negedge clk);
    cmd_snap = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    chk("abort.pre_idx", {30'd0, out_idx}, 32'd2);
    chk("abort.pre_valid", {31'd0, out_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort.valid", {31'd0, out_valid}, 32'd0);
    chk("abort.state", {30'd0, state}, 32'd0);
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.data", out_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("abort.after", 2'd0, 0, 0, 0, 0, 0, 0);
    end
    out_ready = 1'b0;

`ifdef STAT_WINDOW_EN
    begin
      int run_len, snaps;
      logic [1:0] prev;
      doReset();
      window_len = 32'd4;
      out_ready = 1'b1;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      run_len = 0; snaps = 0; prev = 2'd1;
      for (int k = 0; k < 40; k++) begin
        if (state == 2'd1) run_len++;
        if (state == 2'd2 && prev != 2'd2) begin
          chk("win4.run_len", run_len, 4);
          snaps++;
          run_len = 0;
        end
        prev = state;
        @(negedge clk);
      end
      chk("win4.snap_count", snaps, 4);
      doReset();
      window_len = 32'd0;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      snaps = 0;
      for (int k = 0; k < 50; k++) begin
        if (state == 2'd2) snaps++;
        @(negedge clk);
      end
      chk("win0.snap_count", snaps, 0);
      chk("win0.state", {30'd0, state}, 32'd1);
      out_ready = 1'b0;
    end
`endif

    // Random commands against the model.
    doReset();
    modelReset();
`ifdef STAT_WINDOW_EN
    window_len = $urandom_range(0, 6);
`endif
    for (int k = 0; k < 600; k++) begin
      checkModel($sformatf("rand%0d", k));
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 1) == 1);
      r_cnt = $urandom; i_cnt = $urandom; j_cnt = $urandom; tot_cnt = $urandom;
      modelStep();
      @(negedge clk);
    end
    checkModel("rand_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stat_ctrl.md
STAT_CTRL -- requirements
Module: stat_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are listed as name direction width meaning.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 cmd_start, cmd_stop, cmd_clear, cmd_snap  in  1 each  single-cycle command strobes.
REQ-005 r_cnt, i_cnt, j_cnt, tot_cnt  in  32 each  live values from the instruction-type counters.
REQ-006 cnt_en  out  1  registered count enable to the counters.
REQ-007 cnt_clr  out  1  registered one-cycle clear pulse to the counters.
REQ-008 out_valid  out  1, out_ready  in  1, out_data  out  32, out_idx  out  2, out_last  out  1  readout stream.
REQ-009 state  out  2  current FSM state; busy  out  1  high when state is SNAP or SEND.
REQ-010 window_len  in  32  auto-snapshot period in cycles; present only when STAT_WINDOW_EN is defined.

Function
REQ-011 The FSM SHALL have states IDLE=0, RUN=1, SNAP=2, SEND=3.
REQ-012 cnt_en SHALL be 1 exactly while state==RUN, so counters are frozen during SNAP and SEND.
REQ-013 IDLE: cmd_snap -> SNAP; else cmd_start -> RUN; otherwise stay.
REQ-014 RUN: cmd_stop -> IDLE (priority); else cmd_snap or window expiry -> SNAP; cmd_start ignored.
REQ-015 SNAP SHALL last exactly one cycle, latch r_cnt, i_cnt, j_cnt, tot_cnt into four shadow registers on its exit edge, set out_idx=0, and go to SEND.
REQ-016 SEND: out_valid=1, out_data=shadow[out_idx] in order r, i, j, total; out_last=1 when out_idx==3.
REQ-017 out_data, out_idx, out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-018 On each cycle with out_valid and out_ready both high, out_idx SHALL increment; after the handshake with out_idx==3, out_valid SHALL drop next cycle.
REQ-019 On leaving SEND, the next state SHALL be RUN if SNAP was entered from RUN and no stop is pending, otherwise IDLE.
REQ-020 cmd_stop seen in SNAP or SEND SHALL set a pending-stop flag, cleared when SEND exits.
REQ-021 cmd_start, cmd_snap, cmd_clear in SNAP or SEND SHALL be ignored.
REQ-022 cmd_clear in IDLE or RUN SHALL produce cnt_clr=1 for exactly the following cycle without changing state; clear with stop or snap in the same cycle SHALL apply both.
REQ-023 Back-to-back cmd_clear strobes SHALL produce cnt_clr high for the same number of consecutive cycles.
REQ-024 Shadow registers SHALL keep their values until the next SNAP.

Reset
REQ-025 Reset SHALL force state=IDLE, cnt_en=0, cnt_clr=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, shadows=0, pending-stop=0, window counter=0.
REQ-026 Reset asserted mid-SEND SHALL abort the transfer; no resumption after release.

Configuration
REQ-027 With STAT_WINDOW_EN defined: a 32-bit window counter increments each RUN cycle, is held in other states, and resets to 0 on entering SNAP or IDLE; when it reaches window_len-1 in RUN with window_len!=0, the FSM enters SNAP next cycle.
REQ-028 With STAT_WINDOW_EN defined: window_len==0 disables auto-snapshot; window expiry and cmd_snap in the same cycle produce one snapshot; cmd_stop wins over expiry.
REQ-029 Without STAT_WINDOW_EN: the window_len port and window counter are absent, and snapshots occur only on cmd_snap.

Verification
REQ-030 Reset, cmd_start, 5 cycles, cmd_stop -> cnt_en high for exactly 5 cycles, state back to 0, cnt_clr never high.
REQ-031 RUN with inputs r=7, i=3, j=1, tot=11, cmd_snap, out_ready=1 -> SNAP for 1 cycle, then data 7, 3, 1, 11 on 4 consecutive cycles with idx 0..3, out_last only on 11, return to RUN.
REQ-032 SEND with out_ready low for 3 cycles on idx=1 -> data=3 held for 4 cycles; cmd_stop mid-SEND -> IDLE after last word.
REQ-033 cmd_clear plus cmd_snap in RUN -> cnt_clr one cycle, snapshot proceeds; cmd_clear during SEND -> no cnt_clr.
REQ-034 STAT_WINDOW_EN with window_len=4 -> SNAP entered after every 4 RUN cycles; window_len=0 -> no auto SNAP in 50 cycles.
REQ-035 Reset pulse at idx=2 in SEND -> out_valid=0 immediately, state=IDLE, shadows=0.
